// File: rtl/riscv_mem_stage.sv
// RISC-V memory stage: issues one aligned load/store per instruction on a simple
// req/ack bus, stalls upstream while waiting, and feeds the MEM/WB pipeline registers.
module riscv_mem_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    enable,
    input  logic [2:0]              i_width,
    input  logic                    i_rd_write,
    input  logic                    i_read,
    input  logic                    i_write,
    input  logic                    i_wb_src,
    input  logic                    i_valid_instr,
    input  logic [DATA_WIDTH-1:0]   i_alu_data,
    input  logic [DATA_WIDTH-1:0]   i_rs2_data,
    input  logic [4:0]              i_rd_addr,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_stall,
    output logic                    o_rd_write,
    output logic                    o_wb_src,
    output logic                    o_valid_instr,
    output logic                    o_misaligned,
    output logic [4:0]              o_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_alu_data,
    output logic [DATA_WIDTH-1:0]   o_load_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state_reg;
    logic                    mem_req_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [STRB_WIDTH-1:0]   mem_wstrb_reg;

    // Copy of the accepted instruction, used to build the MEM/WB entry at ack time
    logic                    cap_read_reg;
    logic [2:0]              cap_width_reg;
    logic [2:0]              cap_offset_reg;
    logic                    cap_rd_write_reg;
    logic                    cap_wb_src_reg;
    logic                    cap_valid_reg;
    logic [4:0]              cap_rd_addr_reg;
    logic [DATA_WIDTH-1:0]   cap_alu_reg;

    logic                    wb_rd_write_reg, wb_rd_write_next;
    logic                    wb_wb_src_reg, wb_wb_src_next;
    logic                    wb_valid_reg, wb_valid_next;
    logic                    wb_misaligned_reg, wb_misaligned_next;
    logic [4:0]              wb_rd_addr_reg, wb_rd_addr_next;
    logic [DATA_WIDTH-1:0]   wb_alu_reg, wb_alu_next;
    logic [DATA_WIDTH-1:0]   wb_load_reg, wb_load_next;

    logic                    access;
    logic                    misaligned;
    logic                    aligned_access;
    logic [2:0]              offset;
    logic [3:0]              size_bytes;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [STRB_WIDTH-1:0]   wstrb_next;

    assign access         = i_read | i_write;
    assign offset         = i_alu_data[2:0];
    assign size_bytes     = 4'd1 << i_width[1:0];
    assign misaligned     = |(offset & 3'(size_bytes - 4'd1));
    assign aligned_access = access & ~misaligned;
    assign addr_aligned   = {i_alu_data[ADDR_WIDTH-1:3], 3'b000};
    assign wdata_next     = i_rs2_data << {offset, 3'b000};

    // A lane is enabled when it falls inside [offset, offset + size)
    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
            assign wstrb_next[gi] = i_write
                                  && (4'(gi) >= {1'b0, offset})
                                  && (4'(gi) < ({1'b0, offset} + size_bytes));
        end
    endgenerate

    function automatic logic [63:0] extend_load(input logic [63:0] rdata,
                                                input logic [2:0]  lane_offset,
                                                input logic [2:0]  width);
        logic [63:0] lane;
        lane = rdata >> {lane_offset, 3'b000};
        case (width[1:0])
            2'b00:   extend_load = {{56{lane[7]  & ~width[2]}}, lane[7:0]};
            2'b01:   extend_load = {{48{lane[15] & ~width[2]}}, lane[15:0]};
            2'b10:   extend_load = {{32{lane[31] & ~width[2]}}, lane[31:0]};
            default: extend_load = lane;
        endcase
    endfunction

    assign o_stall = (state_reg == IDLE) ? aligned_access : ~i_mem_ack;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg        <= IDLE;
            mem_req_reg      <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            mem_wstrb_reg    <= '0;
            cap_read_reg     <= 1'b0;
            cap_width_reg    <= '0;
            cap_offset_reg   <= '0;
            cap_rd_write_reg <= 1'b0;
            cap_wb_src_reg   <= 1'b0;
            cap_valid_reg    <= 1'b0;
            cap_rd_addr_reg  <= '0;
            cap_alu_reg      <= '0;
        end else if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (aligned_access) begin
                        state_reg        <= REQ;
                        mem_req_reg      <= 1'b1;
                        mem_we_reg       <= i_write;
                        mem_addr_reg     <= addr_aligned;
                        mem_wdata_reg    <= wdata_next;
                        mem_wstrb_reg    <= wstrb_next;
                        cap_read_reg     <= i_read;
                        cap_width_reg    <= i_width;
                        cap_offset_reg   <= offset;
                        cap_rd_write_reg <= i_rd_write;
                        cap_wb_src_reg   <= i_wb_src;
                        cap_valid_reg    <= i_valid_instr;
                        cap_rd_addr_reg  <= i_rd_addr;
                        cap_alu_reg      <= i_alu_data;
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Stalled cycles push a bubble; the ack cycle retires the captured access
    always_comb begin
        wb_rd_write_next   = wb_rd_write_reg;
        wb_wb_src_next     = wb_wb_src_reg;
        wb_valid_next      = wb_valid_reg;
        wb_misaligned_next = wb_misaligned_reg;
        wb_rd_addr_next    = wb_rd_addr_reg;
        wb_alu_next        = wb_alu_reg;
        wb_load_next       = wb_load_reg;
        if (o_stall) begin
            wb_rd_write_next   = 1'b0;
            wb_valid_next      = 1'b0;
            wb_misaligned_next = 1'b0;
        end else if (state_reg == REQ) begin
            wb_rd_write_next   = cap_rd_write_reg;
            wb_wb_src_next     = cap_wb_src_reg;
            wb_valid_next      = cap_valid_reg;
            wb_misaligned_next = 1'b0;
            wb_rd_addr_next    = cap_rd_addr_reg;
            wb_alu_next        = cap_alu_reg;
            wb_load_next       = cap_read_reg
                               ? extend_load(i_mem_rdata, cap_offset_reg, cap_width_reg)
                               : '0;
        end else begin
            wb_rd_write_next   = i_rd_write & ~(access & misaligned);
            wb_wb_src_next     = i_wb_src;
            wb_valid_next      = i_valid_instr;
            wb_misaligned_next = access & misaligned;
            wb_rd_addr_next    = i_rd_addr;
            wb_alu_next        = i_alu_data;
            wb_load_next       = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wb_rd_write_reg   <= 1'b0;
            wb_wb_src_reg     <= 1'b0;
            wb_valid_reg      <= 1'b0;
            wb_misaligned_reg <= 1'b0;
            wb_rd_addr_reg    <= '0;
            wb_alu_reg        <= '0;
            wb_load_reg       <= '0;
        end else if (enable) begin
            wb_rd_write_reg   <= wb_rd_write_next;
            wb_wb_src_reg     <= wb_wb_src_next;
            wb_valid_reg      <= wb_valid_next;
            wb_misaligned_reg <= wb_misaligned_next;
            wb_rd_addr_reg    <= wb_rd_addr_next;
            wb_alu_reg        <= wb_alu_next;
            wb_load_reg       <= wb_load_next;
        end
    end

    assign o_mem_req     = mem_req_reg;
    assign o_mem_we      = mem_we_reg;
    assign o_mem_addr    = mem_addr_reg;
    assign o_mem_wdata   = mem_wdata_reg;
    assign o_mem_wstrb   = mem_wstrb_reg;
    assign o_rd_write    = wb_rd_write_reg;
    assign o_wb_src      = wb_wb_src_reg;
    assign o_valid_instr = wb_valid_reg;
    assign o_misaligned  = wb_misaligned_reg;
    assign o_rd_addr     = wb_rd_addr_reg;
    assign o_alu_data    = wb_alu_reg;
    assign o_load_data   = wb_load_reg;

endmodule
